// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared widths, default coefficients and FSM states for the IIR pole stage
package iir_pkg;

  localparam int DATA_W = 12;
  localparam int COE_W  = 12;
  localparam int SUM_W  = 24;
  localparam int ACC_W  = 26;

  localparam logic signed [COE_W-1:0] A1_DEF       = -12'sd1843;
  localparam logic signed [COE_W-1:0] A2_DEF       = 12'sd840;
  localparam int                      COE_FRAC_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/iir_pole_mult.sv
// rtl/iir_pole_mult.sv - combinational 12x12 signed multiplier shared by the pole FSM
module iir_pole_mult
  import iir_pkg::*;
(
  input  logic signed [COE_W-1:0]  i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [SUM_W-1:0]  o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/iir_pole.sv
// rtl/iir_pole.sv - feedback half of the biquad: y = (Xin - A1*y1 - A2*y2) >>> COE_FRAC
// Build option: define IIR_POLE_SAT_EN to saturate y instead of wrapping it.
module iir_pole
  import iir_pkg::*;
#(
  parameter logic signed [COE_W-1:0] A1       = A1_DEF,
  parameter logic signed [COE_W-1:0] A2       = A2_DEF,
  parameter int                      COE_FRAC = COE_FRAC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [SUM_W-1:0]  Xin,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] Yout,
  output logic                     out_valid,
  output logic                     ovf
);

  state_t                    r_state, w_next;
  logic signed [ACC_W-1:0]   r_acc, w_acc_next, w_sub, w_shift;
  logic signed [DATA_W-1:0]  r_y1, r_y2, r_yout, w_hist, w_lim;
  logic signed [COE_W-1:0]   w_coef;
  logic signed [SUM_W-1:0]   w_prod;
  logic                      r_out_valid, r_ovf, w_range_err;

  iir_pole_mult u_mult (
    .i_a (w_coef),
    .i_b (w_hist),
    .o_p (w_prod)
  );

  assign w_sub = r_acc - {{(ACC_W-SUM_W){w_prod[SUM_W-1]}}, w_prod};

  always_comb begin
    w_next     = r_state;
    w_coef     = A1;
    w_hist     = r_y1;
    w_acc_next = r_acc;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_acc_next = {{(ACC_W-SUM_W){Xin[SUM_W-1]}}, Xin};
          w_next     = MUL1;
        end
      end
      MUL1: begin
        w_acc_next = w_sub;
        w_next     = MUL2;
      end
      MUL2: begin
        w_coef     = A2;
        w_hist     = r_y2;
        w_acc_next = w_sub;
        w_next     = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Result is formed from the final accumulator value so that Yout and out_valid land together in DONE.
  assign w_shift     = w_acc_next >>> COE_FRAC;
  assign w_range_err = !((&w_shift[ACC_W-1:DATA_W-1]) || !(|w_shift[ACC_W-1:DATA_W-1]));

`ifdef IIR_POLE_SAT_EN
  assign w_lim = !w_range_err ? w_shift[DATA_W-1:0] :
                 w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign w_lim = w_shift[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_yout      <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_acc       <= w_acc_next;
      r_out_valid <= (r_state == MUL2);
      if (r_state == MUL2) begin
        r_yout <= w_lim;
        r_y1   <= w_lim;
        r_y2   <= r_y1;
        if (w_range_err) r_ovf <= 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign Yout      = r_yout;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_iir_pole.sv
// tb/tb_iir_pole.sv - randomized self-checking bench for iir_pole against an arithmetic reference model
`timescale 1ns/1ps
module tb_iir_pole;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [23:0] Xin = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] Yout;
  logic               out_valid;
  logic               ovf;

  int n_tests = 0;
  int n_fail  = 0;

  int m_y1 = 0, m_y2 = 0;
  bit m_ovf = 1'b0;

  iir_pole dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Xin       (Xin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Yout      (Yout),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_y1 = 0; m_y2 = 0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input int x, output int y);
    longint acc, q;
    acc = longint'(x) + 1843 * longint'(m_y1) - 840 * longint'(m_y2);
    q = acc / 1024;
    if (acc < 0 && (acc % 1024) != 0) q = q - 1;
    if (q > 2047 || q < -2048) m_ovf = 1'b1;
`ifdef IIR_POLE_SAT_EN
    if (q > 2047) y = 2047;
    else if (q < -2048) y = -2048;
    else y = int'(q);
`else
    y = int'(((q % 4096) + 4096) % 4096);
    if (y >= 2048) y = y - 4096;
`endif
    m_y2 = m_y1;
    m_y1 = y;
  endtask

  task automatic do_reset(input bool_chk);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; Xin = 24'sd5000;
    repeat (3) @(negedge clk);
    if (bool_chk) begin
      check("rst_yout", Yout, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_ovf", ovf, 0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic send(input int x, input string tag, output int y_exp);
    int n, lat;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "_ready_wait"}, in_ready, 1);
    Xin = x[23:0]; in_valid = 1'b1;
    model_step(x, y_exp);
    @(negedge clk);
    in_valid = 1'b0; Xin = $urandom;
    lat = 1;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_yout"}, Yout, y_exp);
    check({tag, "_ovf"}, ovf, m_ovf);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int y;
    int exp_y [12];
    bit exp_v [12];
    int accepts;

    do_reset(1);

    send(102400, "imp0", y); check("imp0_const", Yout, 100);
    send(0, "imp1", y);      check("imp1_const", Yout, 179);
    send(0, "imp2", y);      check("imp2_const", Yout, 240);

    accepts = 0;
    for (int i = 0; i < 12; i++) begin exp_v[i] = 1'b0; exp_y[i] = 0; end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 8) check($sformatf("hs_ready_%0d", i), in_ready, (i % 4 == 0));
      check($sformatf("hs_out_valid_%0d", i), out_valid, exp_v[i]);
      if (exp_v[i]) check($sformatf("hs_yout_%0d", i), Yout, exp_y[i]);
      if (i < 8) begin
        Xin = 24'($urandom_range(0, 200000)) - 24'sd100000;
        in_valid = 1'b1;
        if (in_ready) begin
          accepts++;
          model_step(int'(Xin), y);
          if (i + 3 < 12) begin exp_v[i+3] = 1'b1; exp_y[i+3] = y; end
        end
      end else in_valid = 1'b0;
    end
    check("hs_accepts", accepts, 2);

    do_reset(0);
`ifdef IIR_POLE_SAT_EN
    send(3072000, "ovf0", y); check("ovf0_const", Yout, 2047);
`else
    send(3072000, "ovf0", y); check("ovf0_const", Yout, -1096);
`endif
    check("ovf0_flag", ovf, 1);
    send(0, "ovf1", y);
    check("ovf1_sticky", ovf, 1);

    do_reset(0);
    send(102400, "mid_pre", y);
    Xin = 24'sd50000; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("mid_no_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("mid_ovf_clear", ovf, 0);
    send(102400, "mid_post", y); check("mid_post_const", Yout, 100);

    do_reset(0);
    send(-1, "neg0", y); check("neg0_const", Yout, -1);
    send(0, "neg1", y);

    do_reset(0);
    for (int k = 0; k < 24; k++) begin
      send(int'($urandom_range(0, 1000000)) - 500000, $sformatf("rnd%0d", k), y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
